// File: rtl/parity_step_counter.sv
// Even/odd stepping counter with load, wrap pulse and saturating wrap count.
// Define PSC_DOWN_EN to add the dir port and the down-count path.
module parity_step_counter #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              oe,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
`ifdef PSC_DOWN_EN
    input  logic              dir,
`endif
    output logic [WIDTH-1:0]  out,
    output logic              wrap,
    output logic              par_ok,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic             aligned;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] out_nxt;
    logic             wrap_nxt;

    assign aligned = (out[0] == oe);
    assign par_ok  = aligned;

    // Aligned values jump by 2 to the next same-parity value, else by 1.
    assign step = {{(WIDTH-1){1'b0}}, aligned, ~aligned};
    assign sum  = {1'b0, out} + step;

`ifdef PSC_DOWN_EN
    logic [WIDTH:0] diff;

    // MSB of the extended difference is the borrow.
    assign diff = {1'b0, out} - step;

    always_comb begin
        out_nxt  = sum[WIDTH-1:0];
        wrap_nxt = sum[WIDTH];
        if (dir) begin
            out_nxt  = diff[WIDTH-1:0];
            wrap_nxt = diff[WIDTH];
        end
    end
`else
    always_comb begin
        out_nxt  = sum[WIDTH-1:0];
        wrap_nxt = sum[WIDTH];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            out  <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
            out  <= out_nxt;
            wrap <= wrap_nxt;
        end else begin
            wrap <= 1'b0;
        end
    end

    // Counts registered wrap pulses; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            wrap_cnt <= '0;
        end else if (wrap && (wrap_cnt != WRAP_MAX)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_step_counter.sv
// Directed self-checking bench for parity_step_counter.
// A second instance with WRAP_W=2 exercises wrap_cnt saturation.
module tb_parity_step_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       oe = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       dir = 1'b0;

    logic [2:0] out, out2;
    logic       wrap, wrap2;
    logic       par_ok, par_ok2;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_step_counter #(.WIDTH(3), .WRAP_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .oe(oe),
        .load(load), .load_val(load_val),
`ifdef PSC_DOWN_EN
        .dir(dir),
`endif
        .out(out), .wrap(wrap), .par_ok(par_ok),
        .wrap_cnt(wrap_cnt)
    );

    parity_step_counter #(.WIDTH(3), .WRAP_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .oe(oe),
        .load(load), .load_val(load_val),
`ifdef PSC_DOWN_EN
        .dir(dir),
`endif
        .out(out2), .wrap(wrap2), .par_ok(par_ok2),
        .wrap_cnt(wrap_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Load v, then one advance with mode m; compare out and wrap.
    task automatic edge_case(input string tag, input logic [2:0] v,
                             input logic m, input logic d,
                             input logic [2:0] eo, input logic ew);
        load = 1'b1; load_val = v; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; oe = m; dir = d;
        tick();
        en = 1'b0;
        check({tag, "_out"}, 32'(out), 32'(eo));
        check({tag, "_wrap"}, 32'(wrap), 32'(ew));
    endtask

    initial begin
        logic [2:0] exp_odd  [5];
        logic [2:0] exp_even [5];
        logic [2:0] exp_alt  [4];
        logic [1:0] exp_sat  [5];
        exp_odd  = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1};
        exp_even = '{3'd2, 3'd4, 3'd6, 3'd0, 3'd2};
        exp_alt  = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_sat  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state
        tick();
        check("rst_out", 32'(out), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_wcnt", 32'(wrap_cnt), 0);
        check("rst_parok_even", 32'(par_ok), 1);
        oe = 1'b1;
        #1;
        check("rst_parok_odd", 32'(par_ok), 0);

        // Odd run
        rst = 1'b0; en = 1'b1; oe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("odd_out%0d", i), 32'(out), 32'(exp_odd[i]));
            check($sformatf("odd_wrap%0d", i), 32'(wrap), (i == 4) ? 1 : 0);
        end

        // Even run
        oe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("even_out%0d", i), 32'(out), 32'(exp_even[i]));
            check($sformatf("even_wrap%0d", i), 32'(wrap), (i == 3) ? 1 : 0);
            check($sformatf("even_wcnt%0d", i), 32'(wrap_cnt), (i == 4) ? 2 : 1);
        end

        // Load beats enable and clears wrap_cnt
        load = 1'b1; load_val = 3'd4; en = 1'b1; oe = 1'b1;
        tick();
        check("load_out", 32'(out), 4);
        check("load_parok", 32'(par_ok), 0);
        check("load_wcnt", 32'(wrap_cnt), 0);
        load = 1'b0;
        tick();
        check("load_next", 32'(out), 5);
        check("load_next_parok", 32'(par_ok), 1);
        rst = 1'b1; load = 1'b1;
        tick();
        check("rst_load_out", 32'(out), 0);
        rst = 1'b0; load = 1'b0;

        // Alternating mode
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            oe = (i % 2 == 0);
            tick();
            check($sformatf("alt_out%0d", i), 32'(out), 32'(exp_alt[i]));
            check($sformatf("alt_parok%0d", i), 32'(par_ok), 1);
            check($sformatf("alt_wrap%0d", i), 32'(wrap), 0);
        end

        // Hold
        en = 1'b0;
        tick();
        check("hold_out", 32'(out), 4);

        // Up boundaries
        edge_case("up_odd_7", 3'd7, 1'b1, 1'b0, 3'd1, 1'b1);
        edge_case("up_odd_6", 3'd6, 1'b1, 1'b0, 3'd7, 1'b0);
        edge_case("up_even_6", 3'd6, 1'b0, 1'b0, 3'd0, 1'b1);
        edge_case("up_even_7", 3'd7, 1'b0, 1'b0, 3'd0, 1'b1);

`ifdef PSC_DOWN_EN
        // Down run
        do_reset();
        en = 1'b1; dir = 1'b1; oe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("dn_out%0d", i), 32'(out), (i == 4) ? 6 : 32'(6 - 2 * i));
            check($sformatf("dn_wrap%0d", i), 32'(wrap), (i == 0 || i == 4) ? 1 : 0);
        end
        en = 1'b0;
        do_reset();
        en = 1'b1; oe = 1'b1;
        tick();
        check("dn_odd_0_out", 32'(out), 7);
        check("dn_odd_0_wrap", 32'(wrap), 1);
        en = 1'b0;
        edge_case("dn_odd_1", 3'd1, 1'b1, 1'b1, 3'd7, 1'b1);
        edge_case("dn_even_0", 3'd0, 1'b0, 1'b1, 3'd6, 1'b1);
        edge_case("dn_even_1", 3'd1, 1'b0, 1'b1, 3'd0, 1'b0);
        dir = 1'b0;
`endif

        // Saturation: even up from 0 wraps every 4th cycle
        do_reset();
        en = 1'b1; oe = 1'b0; dir = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check($sformatf("sat_out%0d", i), 32'(out2), 32'((2 * i) % 8));
            if (i % 4 == 1 && i > 1) begin
                check($sformatf("sat_w2_%0d", i), 32'(wrap_cnt2),
                      32'(exp_sat[(i - 5) / 4]));
                check($sformatf("sat_w8_%0d", i), 32'(wrap_cnt),
                      32'((i - 1) / 4));
            end
        end
        check("sat_pending_wrap", 32'(wrap), 1);

        // Reset mid-run drops the pending increment
        rst = 1'b1; load = 1'b1; load_val = 3'd5;
        tick();
        check("midrst_out", 32'(out), 0);
        check("midrst_wrap", 32'(wrap), 0);
        check("midrst_wcnt", 32'(wrap_cnt), 0);
        check("midrst_wcnt2", 32'(wrap_cnt2), 0);
        rst = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        check("midrst_hold_wcnt", 32'(wrap_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
